instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32, SHALL set the PC, branch offset and memory address width.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the instruction width.
REQ-003 Parameter RESET_PC, default 32'h0, SHALL set the PC value loaded at reset.
REQ-004 Port list, in order:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- PCsrc  in  1  branch taken for the instruction currently presented.
- ImmOp  in  ADDRESS_WIDTH  sign-extended branch offset for the presented instruction.
- stall  in  1  downstream not ready; holds the presented instruction.
- imem_req  out  1  instruction memory read request.
- imem_addr  out  ADDRESS_WIDTH  read address.
- imem_ack  in  1  read data valid; completes the request.
- imem_rdata  in  DATA_WIDTH  read data.
- instr  out  DATA_WIDTH  fetched instruction.
- instr_valid  out  1  instr and PC are valid.
- PC  out  ADDRESS_WIDTH  address of instr.
- misalign  out  1  sticky misaligned-target flag; present only with FETCH_MISALIGN_CHK_EN.

Function
REQ-005 The FSM SHALL have states IDLE, REQ, HOLD and, with the macro, HALT.
REQ-006 IDLE SHALL last exactly one cycle after reset release, then move to REQ.
REQ-007 In REQ: imem_req=1 and imem_addr=PC; both SHALL stay stable until the cycle in which imem_ack=1.
REQ-008 On imem_ack in REQ: the block SHALL capture imem_rdata into instr and move to HOLD; instr_valid=1 from the next cycle.
REQ-009 imem_ack in the same cycle that imem_req rises SHALL be accepted (zero-wait memory).
REQ-010 In HOLD: instr_valid=1, imem_req=0, and instr and PC held constant.
REQ-011 Consume is defined as HOLD && !stall; PCsrc and ImmOp SHALL be sampled only in the consume cycle.
REQ-012 On consume: PC SHALL load PC+ImmOp if PCsrc=1, else PC+4; the FSM SHALL move to REQ and instr_valid SHALL drop next cycle.
REQ-013 PC arithmetic SHALL be modulo 2^ADDRESS_WIDTH; 32'hFFFFFFFC+4 wraps to 32'h0 and negative ImmOp wraps likewise.
REQ-014 imem_ack outside REQ SHALL be ignored.
REQ-015 stall outside HOLD SHALL have no effect.
REQ-016 Minimum issue interval SHALL be 2 cycles per instruction: consume at t, REQ at t+1, instr_valid at t+2 with zero-wait ack.

Reset
REQ-017 While rst_n=0 at a clock edge: state=IDLE, PC=RESET_PC, instr=0, instr_valid=0, imem_req=0, imem_addr=RESET_PC, misalign=0.
REQ-018 Reset asserted mid-request SHALL drop imem_req at that edge; a late imem_ack after reset SHALL be ignored, and the first post-reset request SHALL use RESET_PC.

Configuration
REQ-019 With FETCH_MISALIGN_CHK_EN defined: a consume with PCsrc=1 and (PC+ImmOp)[1:0]!=0 SHALL load the target into PC, set misalign=1, and enter HALT.
REQ-020 HALT SHALL issue no requests and hold instr_valid=0; only reset leaves HALT and clears misalign.
REQ-021 Without FETCH_MISALIGN_CHK_EN: the misalign port and HALT SHALL not exist, and the branch target SHALL have bits [1:0] forced to 2'b00.

Verification
REQ-022 Reset release with RESET_PC=0 and zero-wait ack returning 32'h00500093 -> imem_req at cycle 1 with addr 0; instr=32'h00500093 and instr_valid=1 at cycle 2.
REQ-023 Sequential fetch of 3 instructions with stall=0 and PCsrc=0 -> imem_addr 0, 4, 8, one instruction every 2 cycles.
REQ-024 PC=32'h10, PCsrc=1, ImmOp=32'hFFFFFFF8 -> next imem_addr=32'h08; stall=1 for 3 cycles beforehand -> instr and PC unchanged, no imem_req.
REQ-025 imem_ack delayed 4 cycles -> imem_req and imem_addr stable for all 4 cycles; rst_n low on cycle 2 -> imem_req=0 next edge, the stray ack is ignored, and the refetch uses addr RESET_PC.
REQ-026 PC=32'hFFFFFFFC, PCsrc=0 -> next addr 32'h0; with the macro, PC=32'h10, PCsrc=1, ImmOp=32'h6 -> misalign=1 and no further imem_req until reset.

Source files
------------

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit: IDLE -> REQ -> HOLD handshake with branch/sequential PC.
// Optional FETCH_MISALIGN_CHK_EN halts on misaligned branch targets instead of force-aligning them.
module instr_fetch #(
  parameter int unsigned             ADDRESS_WIDTH = 32,
  parameter int unsigned             DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC     = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     PCsrc,
  input  logic [ADDRESS_WIDTH-1:0] ImmOp,
  input  logic                     stall,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                     imem_ack,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic                     instr_valid,
`ifdef FETCH_MISALIGN_CHK_EN
  output logic [ADDRESS_WIDTH-1:0] PC,
  output logic                     misalign
`else
  output logic [ADDRESS_WIDTH-1:0] PC
`endif
);

  localparam logic [ADDRESS_WIDTH-1:0] PcStep = ADDRESS_WIDTH'(4);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
`ifdef FETCH_MISALIGN_CHK_EN
    StHold,
    StHalt
`else
    StHold
`endif
  } state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0]    instr_q, instr_d;
  logic [ADDRESS_WIDTH-1:0] raw_target;
  logic [ADDRESS_WIDTH-1:0] target;

  // All arithmetic wraps naturally at ADDRESS_WIDTH bits.
  assign raw_target = pc_q + ImmOp;

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign_q, misalign_d;
  assign target   = raw_target;
  assign misalign = misalign_q;
`else
  localparam logic [ADDRESS_WIDTH-1:0] AlignMask = ~ADDRESS_WIDTH'(3);
  assign target = raw_target & AlignMask;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
`ifdef FETCH_MISALIGN_CHK_EN
    misalign_d = misalign_q;
`endif
    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = StHold;
        end
      end
      StHold: begin
        // Branch inputs are only meaningful in the consume cycle.
        if (!stall) begin
          state_d = StReq;
          if (PCsrc) begin
            pc_d = target;
`ifdef FETCH_MISALIGN_CHK_EN
            if (target[1:0] != 2'b00) begin
              misalign_d = 1'b1;
              state_d    = StHalt;
            end
`endif
          end else begin
            pc_d = pc_q + PcStep;
          end
        end
      end
`ifdef FETCH_MISALIGN_CHK_EN
      StHalt: state_d = StHalt;
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      instr_q <= '0;
`ifdef FETCH_MISALIGN_CHK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
`ifdef FETCH_MISALIGN_CHK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign imem_req    = (state_q == StReq);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == StHold);
  assign PC          = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a fetch scoreboard; covers the FETCH_MISALIGN_CHK_EN build too.
module tb_instr_fetch;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          PCsrc;
  logic [AW-1:0] ImmOp;
  logic          stall;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [DW-1:0] imem_rdata;
  logic [DW-1:0] instr;
  logic          instr_valid;
  logic [AW-1:0] PC;
`ifdef FETCH_MISALIGN_CHK_EN
  logic          misalign;
`endif

  int checks = 0;
  int errors = 0;
  logic [AW+DW-1:0] sb_q[$];
  logic [AW-1:0]    model_pc;
  logic [DW-1:0]    last_instr;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .PCsrc       (PCsrc),
    .ImmOp       (ImmOp),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
`ifdef FETCH_MISALIGN_CHK_EN
    .PC          (PC),
    .misalign    (misalign)
`else
    .PC          (PC)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Caller must be in the request state; returns with the instruction presented.
  task automatic fetch(input logic [DW-1:0] data);
    logic [AW+DW-1:0] e;
    check_bit("req_before_ack", imem_req, 1'b1);
    check_word("addr_before_ack", imem_addr, model_pc);
    imem_ack   = 1'b1;
    imem_rdata = data;
    sb_q.push_back({model_pc, data});
    step();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    check_bit("valid_after_ack", instr_valid, 1'b1);
    check_bit("req_in_hold", imem_req, 1'b0);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_underflow: observed empty queue expected entry");
    end else begin
      e = sb_q.pop_front();
      check_word("sb_instr", instr, e[DW-1:0]);
      check_word("sb_pc", PC, e[AW+DW-1:DW]);
    end
    last_instr = data;
  endtask

  task automatic consume(input logic br, input logic [AW-1:0] imm);
    logic [AW-1:0] t;
    stall = 1'b0;
    PCsrc = br;
    ImmOp = imm;
    t = model_pc + imm;
`ifndef FETCH_MISALIGN_CHK_EN
    t[1:0] = 2'b00;
`endif
    model_pc = br ? t : model_pc + 32'd4;
    step();
    // Garbage outside the consume cycle must be ignored.
    PCsrc = 1'($urandom);
    ImmOp = $urandom;
    check_bit("valid_drop", instr_valid, 1'b0);
    check_bit("req_after_consume", imem_req, 1'b1);
    check_word("addr_after_consume", imem_addr, model_pc);
    check_word("pc_after_consume", PC, model_pc);
  endtask

  initial begin
    rst_n      = 1'b0;
    PCsrc      = 1'b0;
    ImmOp      = '0;
    stall      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    model_pc   = '0;
    last_instr = '0;
    step();
    step();
    check_bit("rst_req", imem_req, 1'b0);
    check_bit("rst_valid", instr_valid, 1'b0);
    check_word("rst_instr", instr, 32'h0);
    check_word("rst_pc", PC, 32'h0);
    check_word("rst_addr", imem_addr, 32'h0);

    // Release: one idle cycle, then request at address 0 with zero-wait ack.
    rst_n = 1'b1;
    step();
    fetch(32'h00500093);
    check_word("first_instr", instr, 32'h00500093);

    // Sequential stream 0, 4, 8.
    consume(1'b0, '0);
    check_word("seq_addr_4", imem_addr, 32'h4);
    fetch(32'h00a00113);
    consume(1'b0, '0);
    check_word("seq_addr_8", imem_addr, 32'h8);
    fetch(32'h002081b3);
    consume(1'b0, '0);
    fetch(32'h11111111);
    consume(1'b0, '0);
    fetch(32'h22222222);
    check_word("at_pc_10", PC, 32'h10);

    // Stall three cycles with a stray ack and branch inputs present, then branch back.
    stall = 1'b1;
    PCsrc = 1'b1;
    ImmOp = 32'h100;
    repeat (3) begin
      imem_ack   = 1'b1;
      imem_rdata = 32'hdeadbeef;
      step();
      check_bit("stall_valid", instr_valid, 1'b1);
      check_bit("stall_no_req", imem_req, 1'b0);
      check_word("stall_instr", instr, last_instr);
      check_word("stall_pc", PC, model_pc);
    end
    imem_ack = 1'b0;
    consume(1'b1, 32'hfffffff8);
    check_word("branch_back_addr", imem_addr, 32'h8);

    // Stall in request has no effect; ack delayed four cycles.
    stall = 1'b1;
    repeat (3) begin
      step();
      check_bit("wait_req", imem_req, 1'b1);
      check_word("wait_addr", imem_addr, 32'h8);
      check_bit("wait_valid", instr_valid, 1'b0);
    end
    fetch(32'h33333333);
    consume(1'b0, '0);

    // Reset in the middle of a request; the stray ack afterwards is ignored.
    step();
    check_bit("pre_rst_req", imem_req, 1'b1);
    rst_n = 1'b0;
    step();
    check_bit("mid_rst_req", imem_req, 1'b0);
    check_word("mid_rst_addr", imem_addr, 32'h0);
    rst_n      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hcafef00d;
    step();
    imem_ack = 1'b0;
    model_pc = 32'h0;
    check_bit("stray_ack_valid", instr_valid, 1'b0);
    check_word("stray_ack_instr", instr, 32'h0);
    check_bit("refetch_req", imem_req, 1'b1);
    check_word("refetch_addr", imem_addr, 32'h0);
    fetch(32'h44444444);

    // Negative offset wraps below zero; sequential wraps past the top.
    consume(1'b1, 32'hfffffffc);
    check_word("neg_wrap_addr", imem_addr, 32'hfffffffc);
    fetch(32'h55555555);
    consume(1'b0, '0);
    check_word("top_wrap_addr", imem_addr, 32'h0);
    fetch(32'h66666666);
    consume(1'b1, 32'h10);
    fetch(32'h77777777);

`ifdef FETCH_MISALIGN_CHK_EN
    stall = 1'b0;
    PCsrc = 1'b1;
    ImmOp = 32'h6;
    step();
    PCsrc = 1'b0;
    repeat (3) begin
      imem_ack = 1'b1;
      check_bit("halt_misalign", misalign, 1'b1);
      check_bit("halt_no_req", imem_req, 1'b0);
      check_bit("halt_valid", instr_valid, 1'b0);
      check_word("halt_pc", PC, 32'h16);
      step();
    end
    imem_ack = 1'b0;
    rst_n = 1'b0;
    step();
    check_bit("halt_rst_clear", misalign, 1'b0);
    rst_n = 1'b1;
    step();
    check_bit("halt_rst_req", imem_req, 1'b1);
    check_word("halt_rst_addr", imem_addr, 32'h0);
`else
    consume(1'b1, 32'h6);
    check_word("masked_target", imem_addr, 32'h14);
    fetch(32'h88888888);
`endif

    check_word("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
